// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
// Shared definitions for the multi-channel key debouncer:
//   - key_fsm_e : 2-bit per-channel FSM state encoding
//   - cnt_width : width of a counter that must hold values 0..max_val-1,
//                 never narrower than one bit so degenerate parameters still build
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_fsm_e;

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if
// Bundles the tick/raw-key inputs and the debounced level/event outputs.
//   tick_1ms    : one-clk pulse per millisecond
//   key_in      : raw button levels, 1 = pressed
//   key_state   : debounced level per key
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse once per press after the long-press time
// master = producer of tick/keys (board side), slave = the debouncer.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);

  logic              tick_1ms;
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output tick_1ms, key_in,
    input  key_state, key_press, key_release, key_long
  );

  modport slave (
    input  tick_1ms, key_in,
    output key_state, key_press, key_release, key_long
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
// One debounce channel: 2-FF synchronizer, IDLE/PRESS_WAIT/HELD/RELEASE_WAIT
// FSM, debounce counter, saturating long-press counter and registered outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_1ms    : millisecond tick; all timing counts only on this pulse
//   key_in      : raw asynchronous key level
//   key_state   : debounced level (HELD or RELEASE_WAIT)
//   key_press   : one-cycle pulse when a press is accepted
//   key_release : one-cycle pulse when a release is accepted
//   key_long    : one-cycle pulse when held time reaches LONG_MS
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int            DW        = cnt_width(DEBOUNCE_MS);
  localparam int            LW        = cnt_width(LONG_MS + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_MS - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_MS);
  localparam logic [LW-1:0] LCNT_PRE  = LW'(LONG_MS - 1);
  localparam logic [LW-1:0] LCNT_ONE  = LW'(1);

  logic          sync_meta_r;
  logic          sync_s_r;
  key_fsm_e      state_r;
  key_fsm_e      state_nxt_s;
  logic [DW-1:0] dcnt_r;
  logic [DW-1:0] dcnt_nxt_s;
  logic [LW-1:0] lcnt_r;
  logic [LW-1:0] lcnt_nxt_s;
  logic          level_nxt_s;
  logic          press_nxt_s;
  logic          release_nxt_s;
  logic          long_nxt_s;
  logic          level_r;
  logic          press_r;
  logic          release_r;
  logic          long_r;

  // Two-flop synchronizer bringing the asynchronous key level into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b0;
      sync_s_r    <= 1'b0;
    end else begin
      sync_meta_r <= key_in;
      sync_s_r    <= sync_meta_r;
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      dcnt_r    <= '0;
      lcnt_r    <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
      lcnt_r    <= lcnt_nxt_s;
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
    end
  end

  // Next-state and counter logic; a level change on s takes priority over a tick.
  always_comb begin
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    lcnt_nxt_s  = lcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_s_r) begin
          state_nxt_s = ST_PRESS_WAIT;
          dcnt_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_s_r) begin
          state_nxt_s = ST_IDLE;
          dcnt_nxt_s  = '0;
        end else if (tick_1ms) begin
          if (dcnt_r == DCNT_LAST) begin
            state_nxt_s = ST_HELD;
            dcnt_nxt_s  = '0;
            lcnt_nxt_s  = '0;
          end else begin
            dcnt_nxt_s  = dcnt_r + DCNT_ONE;
          end
        end else begin
          state_nxt_s = ST_PRESS_WAIT;
        end
      end
      ST_HELD: begin
        if (!sync_s_r) begin
          state_nxt_s = ST_RELEASE_WAIT;
          dcnt_nxt_s  = '0;
        end else if (tick_1ms && (lcnt_r != LCNT_MAX)) begin
          // Saturation at LONG_MS is what limits key_long to once per press.
          lcnt_nxt_s  = lcnt_r + LCNT_ONE;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_s_r) begin
          // Release glitch: return to HELD, long-press progress kept.
          state_nxt_s = ST_HELD;
          dcnt_nxt_s  = '0;
        end else if (tick_1ms) begin
          if (dcnt_r == DCNT_LAST) begin
            state_nxt_s = ST_IDLE;
            dcnt_nxt_s  = '0;
            lcnt_nxt_s  = '0;
          end else begin
            dcnt_nxt_s  = dcnt_r + DCNT_ONE;
          end
        end else begin
          state_nxt_s = ST_RELEASE_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        dcnt_nxt_s  = '0;
        lcnt_nxt_s  = '0;
      end
    endcase
  end

  // Output decode: values registered on the edge that samples the qualifying tick.
  always_comb begin
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    level_nxt_s   = 1'b0;
    case (state_r)
      ST_PRESS_WAIT: begin
        if (sync_s_r && tick_1ms && (dcnt_r == DCNT_LAST)) begin
          press_nxt_s = 1'b1;
        end else begin
          press_nxt_s = 1'b0;
        end
      end
      ST_HELD: begin
        if (sync_s_r && tick_1ms && (lcnt_r == LCNT_PRE)) begin
          long_nxt_s = 1'b1;
        end else begin
          long_nxt_s = 1'b0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync_s_r && tick_1ms && (dcnt_r == DCNT_LAST)) begin
          release_nxt_s = 1'b1;
        end else begin
          release_nxt_s = 1'b0;
        end
      end
      default: begin
        press_nxt_s = 1'b0;
      end
    endcase
    if ((state_nxt_s == ST_HELD) || (state_nxt_s == ST_RELEASE_WAIT)) begin
      level_nxt_s = 1'b1;
    end else begin
      level_nxt_s = 1'b0;
    end
  end

  assign key_state   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign key_long    = long_r;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
// Multi-channel push-button debouncer / event generator. Instantiates one
// key_debounce_ch per key and concatenates the per-channel outputs.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key_debounce_if slave (tick_1ms, key_in in; key_state,
//           key_press, key_release, key_long out)
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.slave  bus
);

  logic [N_KEYS-1:0] state_s;
  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] release_s;
  logic [N_KEYS-1:0] long_s;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_1ms    (bus.tick_1ms),
      .key_in      (bus.key_in[g]),
      .key_state   (state_s[g]),
      .key_press   (press_s[g]),
      .key_release (release_s[g]),
      .key_long    (long_s[g])
    );
  end

  assign bus.key_state   = state_s;
  assign bus.key_press   = press_s;
  assign bus.key_release = release_s;
  assign bus.key_long    = long_s;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
// Directed scoreboard bench for key_debounce (N_KEYS=4, DEBOUNCE_MS=3,
// LONG_MS=10, tick every 8 clk). Stimulus pushes expected pulse events
// (kind, key, tick index) into a queue; a monitor pops one entry per observed
// pulse and also requires the pulse to follow a tick edge directly.
module tb_key_debounce;

  typedef struct {
    int kind;
    int key;
    int tick;
  } ev_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;
  logic tick_seen = 1'b0;
  ev_t  exp_q[$];

  key_debounce_if #(.N_KEYS(4)) bus ();

  key_debounce #(
    .N_KEYS      (4),
    .DEBOUNCE_MS (3),
    .LONG_MS     (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick_1ms: one clk high out of every 8
  initial begin
    bus.tick_1ms = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      bus.tick_1ms = 1'b1;
      @(negedge clk);
      bus.tick_1ms = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (bus.tick_1ms) tick_cnt <= tick_cnt + 1;
    tick_seen <= bus.tick_1ms;
  end

  function automatic string kind_name(input int kind);
    return (kind == 0) ? "press" : (kind == 1) ? "release" : "long";
  endfunction

  task automatic push_ev(input int kind, input int key, input int tick);
    ev_t e;
    e.kind = kind;
    e.key  = key;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff bus.tick_1ms);
    @(negedge clk);
  endtask

  // Monitor: every pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      for (int kind = 0; kind < 3; kind++) begin
        logic [3:0] v;
        v = (kind == 0) ? bus.key_press : (kind == 1) ? bus.key_release : bus.key_long;
        for (int k = 0; k < 4; k++) begin
          if (v[k]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL event: got %s key%0d at tick %0d, required no pulse",
                       kind_name(kind), k, tick_cnt);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.kind != kind || e.key != k || e.tick != tick_cnt || !tick_seen) begin
                errors++;
                $display("FAIL event: got %s key%0d tick %0d after_tick=%0b, required %s key%0d tick %0d",
                         kind_name(kind), k, tick_cnt, tick_seen, kind_name(e.kind), e.key, e.tick);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n      = 1'b0;
    bus.key_in = 4'hF;
    repeat (5) @(negedge clk);
    check("reset key_state", 32'(bus.key_state), 32'h0);
    check("reset key_press", 32'(bus.key_press), 32'h0);
    check("reset key_release", 32'(bus.key_release), 32'h0);
    check("reset key_long", 32'(bus.key_long), 32'h0);

    // Reset release with all keys already down: full debounce needed.
    wait_ticks(1);
    rst_n = 1'b1;
    k = tick_cnt;
    for (int i = 0; i < 4; i++) push_ev(0, i, k + 3);
    wait_ticks(2);
    check("post-reset state before 3rd tick", 32'(bus.key_state), 32'h0);
    wait_ticks(1);
    check("post-reset state after press", 32'(bus.key_state), 32'hF);
    bus.key_in = 4'h0;
    for (int i = 0; i < 4; i++) push_ev(1, i, k + 6);
    wait_ticks(3);
    check("post-reset state after release", 32'(bus.key_state), 32'h0);

    // Clean press on key0, held 5 ticks.
    wait_ticks(1);
    k = tick_cnt;
    bus.key_in[0] = 1'b1;
    push_ev(0, 0, k + 3);
    wait_ticks(2);
    check("key0 state before press", 32'(bus.key_state), 32'h0);
    wait_ticks(1);
    check("key0 state at press", 32'(bus.key_state), 32'h1);
    wait_ticks(2);
    bus.key_in[0] = 1'b0;
    push_ev(1, 0, k + 8);
    wait_ticks(3);
    check("key0 state after release", 32'(bus.key_state), 32'h0);

    // Bounce on key1: toggled every 2 ticks, never stable for 3.
    wait_ticks(1);
    for (int i = 0; i < 6; i++) begin
      bus.key_in[1] = ~bus.key_in[1];
      wait_ticks(2);
      check("key1 bounce state", 32'(bus.key_state), 32'h0);
    end
    bus.key_in[1] = 1'b0;
    wait_ticks(4);
    check("key1 state after bounce", 32'(bus.key_state), 32'h0);

    // Long press on key2: held 20 ticks.
    k = tick_cnt;
    bus.key_in[2] = 1'b1;
    push_ev(0, 2, k + 3);
    push_ev(2, 2, k + 13);
    wait_ticks(20);
    bus.key_in[2] = 1'b0;
    push_ev(1, 2, k + 23);
    wait_ticks(2);
    check("key2 state in release wait", 32'(bus.key_state), 32'h4);
    wait_ticks(1);
    check("key2 state at release", 32'(bus.key_state), 32'h0);

    // Release glitch on key3: dropped for one tick, long delayed by one tick.
    wait_ticks(1);
    k = tick_cnt;
    bus.key_in[3] = 1'b1;
    push_ev(0, 3, k + 3);
    push_ev(2, 3, k + 14);
    wait_ticks(7);
    bus.key_in[3] = 1'b0;
    wait_ticks(1);
    check("key3 state during glitch", 32'(bus.key_state), 32'h8);
    bus.key_in[3] = 1'b1;
    wait_ticks(10);
    bus.key_in[3] = 1'b0;
    push_ev(1, 3, k + 21);
    wait_ticks(3);
    check("key3 state after release", 32'(bus.key_state), 32'h0);

    // Reset during key0 PRESS_WAIT while key2 is held.
    wait_ticks(1);
    k = tick_cnt;
    bus.key_in[2] = 1'b1;
    push_ev(0, 2, k + 3);
    wait_ticks(3);
    bus.key_in[0] = 1'b1;
    wait_ticks(1);
    repeat (2) @(negedge clk);
    check("pre-reset state", 32'(bus.key_state), 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid reset key_state", 32'(bus.key_state), 32'h0);
    check("mid reset key_press", 32'(bus.key_press), 32'h0);
    wait_ticks(1);
    rst_n = 1'b1;
    k = tick_cnt;
    push_ev(0, 0, k + 3);
    push_ev(0, 2, k + 3);
    wait_ticks(2);
    check("re-debounce state before 3rd tick", 32'(bus.key_state), 32'h0);
    wait_ticks(1);
    check("re-debounce state at press", 32'(bus.key_state), 32'h5);
    bus.key_in = 4'h0;
    push_ev(1, 0, k + 6);
    push_ev(1, 2, k + 6);
    wait_ticks(3);
    check("final state", 32'(bus.key_state), 32'h0);
    wait_ticks(4);
    check("pending expected events", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-channel push-button debouncer and event generator. It consumes the one-cycle millisecond tick produced by the board's 1 ms tick generator and N raw button inputs. It produces clean key levels plus single-cycle press, release and long-press pulses for the downstream control logic. All timing is expressed in milliseconds and measured only on `tick_1ms` pulses, so the block is independent of the system clock frequency.

## Interface
- `N_KEYS`, default 4: number of independent button channels (1..16).
- `DEBOUNCE_MS`, default 20: consecutive stable ticks required to accept a level change (≥1).
- `LONG_MS`, default 1000: ticks spent in held state before `key_long` fires (> `DEBOUNCE_MS`).

Ports:
- `clk`, in, 1: system clock. One clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `tick_1ms`, in, 1: one-`clk`-wide pulse, once per ms.
- `key_in`, in, `N_KEYS`: raw button levels, asynchronous, 1 = pressed.
- `key_state`, out, `N_KEYS`: debounced level per key.
- `key_press`, out, `N_KEYS`: one-cycle pulse on accepted press.
- `key_release`, out, `N_KEYS`: one-cycle pulse on accepted release.
- `key_long`, out, `N_KEYS`: one-cycle pulse, once per press, at `LONG_MS` held.

## Operation
- Each `key_in` bit passes through a 2-FF synchronizer (reset 0) giving `s`. All logic below uses `s`.
- Each channel has its own FSM:
  - `dcnt`: debounce counter, width clog2(`DEBOUNCE_MS`).
  - `lcnt`: long-press counter, width clog2(`LONG_MS`+1), saturating.
- States:
  - IDLE: `s`=1 → PRESS_WAIT, `dcnt`=0.
  - PRESS_WAIT: `s`=0 → IDLE. Otherwise, on tick: if `dcnt`==`DEBOUNCE_MS`-1 → HELD, `key_press` pulse, `lcnt`=0, `dcnt`=0; else `dcnt`++.
  - HELD: `s`=0 → RELEASE_WAIT, `dcnt`=0. Otherwise, on tick, `lcnt`++ (saturating at `LONG_MS`). `key_long` pulses on the tick where `lcnt` goes `LONG_MS`-1 → `LONG_MS`. No further long pulses until the key returns to IDLE.
  - RELEASE_WAIT: `s`=1 → HELD, `dcnt`=0, `lcnt` retained. Otherwise, on tick: if `dcnt`==`DEBOUNCE_MS`-1 → IDLE, `key_release` pulse, `lcnt`=0; else `dcnt`++. `lcnt` frozen in this state.
- `key_state` = 1 in HELD and RELEASE_WAIT, 0 otherwise.
- Priority: a level change on `s` beats `tick_1ms` in the same cycle. The state changes and no count occurs.
- Channels are fully independent. Any combination of pulses may occur in the same cycle.

## Timing
- Reset: every FSM in IDLE, counters 0, synchronizers 0. All outputs 0 asynchronously on `rst_n` low.
- Deassertion of `rst_n` is synchronized externally. The first active edge after deassertion is a normal cycle.
- All outputs are registered. A pulse is high for exactly the one `clk` cycle following the edge that samples the qualifying tick.
- Input-to-`s` latency is 2 `clk`.
- Press acceptance takes exactly `DEBOUNCE_MS` ticks after `s` rises. Real time is between `DEBOUNCE_MS`-1 and `DEBOUNCE_MS` ms, because the first interval is partial. Release acceptance is identical.
- `key_long` fires `LONG_MS` ticks of HELD after `key_press`, excluding ticks spent in RELEASE_WAIT.
- Reset mid-operation aborts any pending press/release with no pulse emitted. A key still held after reset must be re-debounced in full.

## Structure
- Package/header `key_debounce_pkg`: 2-bit state encodings (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3) and the counter-width function.
- Sub-module `key_debounce_ch` implements one channel: synchronizer, FSM, both counters, and the four outputs. The top instantiates it `N_KEYS` times in a generate loop and concatenates the outputs.

## Test plan
Bench setup: `DEBOUNCE_MS`=3, `LONG_MS`=10, `N_KEYS`=4, bench-driven tick every 8 `clk`.

- Reset: hold `rst_n`=0 with `key_in`=4'hF → all outputs 0. After release, `key_press`=4'hF occurs only after 3 ticks.
- Clean press on key0 held for 5 ticks → one `key_press[0]` pulse 1 clk after the 3rd tick. `key_state[0]`=1 from that cycle.
- Bounce: key1 toggled every 2 ticks for 12 ticks, then 0 → no pulses; `key_state[1]` stays 0.
- Long press: hold key2 for 20 ticks, then release → `key_long[2]` exactly once, 10 ticks after `key_press[2]`. `key_release[2]` fires 3 ticks after release and `key_state[2]` drops with it.
- Release glitch: key3 held, dropped for 1 tick, restored → no `key_release`. `key_long` still fires, delayed by the glitch ticks only.
- Reset asserted mid-PRESS_WAIT on key0 → outputs 0 immediately and no `key_press`. After reset, the full 3 ticks are needed again.
